eprisc_ttl_serial_rx: RTL and testbench
=======================================

# eprisc_ttl_serial_rx

Receive front end for the TTL serial port. It sits between the `iTTLSerialRX` board pin and the I/O controller's register file. It deserialises 8N1 asynchronous frames, or 8E1 when parity is enabled, and queues received bytes in a small first-word-fall-through FIFO. The I/O controller drains the FIFO with a valid/ready handshake and reads sticky error flags.

## Interface
- `CLKS_PER_BIT`, default 16: board clocks per bit period; must be ≥ 4. Counter width is `$clog2(CLKS_PER_BIT)`.
- `FIFO_DEPTH`, default 16: receive FIFO entries; power of two, ≥ 2.
- `iBoardClock`  in  1  single board clock; all logic is on the rising edge.
- `iBoardReset`  in  1  reset, asynchronous assert, active-low.
- `iTTLSerialRX`  in  1  raw, asynchronous serial line; idles high.
- `oRxData`  out  8  FIFO head byte; valid only while `oRxValid` is high.
- `oRxValid`  out  1  FIFO is not empty.
- `iRxReady`  in  1  consumer pop; takes effect only when `oRxValid & iRxReady`.
- `oRxCount`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `oRxOverrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `oRxFramingError`  out  1  sticky: a stop bit was sampled low.
- `oRxParityError`  out  1  sticky parity mismatch; tied to 0 when parity is compiled out.
- `iRxClearErrors`  in  1  one-cycle pulse that clears all sticky flags.

## Operation
- **Synchroniser:** `iTTLSerialRX` passes through 2 flops, both reset to 1. Call the output `rxs`.
- **IDLE:** a 1→0 transition on `rxs` loads the bit counter and moves to START.
- **START:** waits `CLKS_PER_BIT/2` cycles, then samples `rxs`.
  - Sample 1: treated as a glitch; return to IDLE with no flag set.
  - Sample 0: move to DATA.
- **DATA:** samples every `CLKS_PER_BIT` cycles, 8 bits, LSB first, shifting into a holding register.
- **PARITY** (only with the macro): one sample, checked against even parity over the 8 data bits.
- **STOP:** one sample after `CLKS_PER_BIT` cycles.
  - Sample 1: push the byte, or set overrun if the FIFO is full. Return to IDLE.
  - Sample 0: set `oRxFramingError`, discard the byte, go to BREAK.
- **BREAK:** waits for `rxs` = 1, then returns to IDLE. A held-low line produces exactly one framing error.
- **Parity mismatch:** sets `oRxParityError`. The byte is still pushed if the stop bit is good.
- **FIFO push and pop:**
  - A push on a full FIFO with no pop in the same cycle drops the byte and sets `oRxOverrun`. The FIFO contents are unchanged.
  - A push and a pop in the same cycle on a full FIFO are both accepted, with no overrun. The count is unchanged.
  - A push and a pop in the same cycle on an empty FIFO cannot occur, because pop requires valid.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A pop while `oRxValid` = 0 is ignored.
- **Error flags:** if `iRxClearErrors` and a new error event occur in the same cycle, the flag ends set.
- **Reset values:** `oRxData`=0x00, `oRxValid`=0, `oRxCount`=0, all error flags 0, state IDLE.
- **Reset mid-frame:** the partial byte is lost. After release the receiver waits in IDLE for a fresh falling edge.

## Timing
- Pin to `rxs` latency: 2 cycles.
- Start-edge detection happens on the cycle `rxs` first reads 0.
- The first data sample falls `CLKS_PER_BIT/2 + CLKS_PER_BIT` cycles after start detection.
- The stop-bit sample falls `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT` cycles after start detection; add one `CLKS_PER_BIT` with parity.
- `oRxValid` and `oRxData` update on the cycle after the stop sample.
- Error flags set on the cycle after the offending sample.
- Pop: `oRxData` shows the next entry, and `oRxCount` decrements, on the cycle after `oRxValid & iRxReady`.
- Back-to-back frames are supported: a start edge may be accepted on the cycle after returning to IDLE.

## Configuration
- **`EPRISC_TTLSERIAL_PARITY_EN` defined:** the PARITY state exists and frames are 8E1 (11 bit times). `oRxParityError` is live.
- **Undefined:** frames are 8N1 (10 bit times), no PARITY state, and `oRxParityError` is constant 0.

## Structure
- **Package `eprisc_serial_pkg`:** state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and the data-bit count constant (8).
- **Sub-module `eprisc_rx_fifo`:** parameterised by `FIFO_DEPTH`, 8-bit first-word fall-through. It provides push, pop, full, empty, count, and performs the simultaneous push/pop arbitration.

## Test plan
Bench uses `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- **Single byte:** frame 0x55, pin-accurate → `oRxValid` rises 2 + 8 + 144 + 1 cycles after the pin falls, `oRxData`=0x55, `oRxCount`=1. Pulse `iRxReady` → valid drops the next cycle.
- **Glitch:** 4-cycle low pulse on idle line → no push, no flags, state back in IDLE.
- **Framing error:** frame 0xA3 with stop bit low, then line held low 40 bit times → `oRxFramingError`=1 once, FIFO empty. After line returns high, frame 0x3C is received correctly.
- **Overrun:** 5 frames 0x01..0x05 with no pops → `oRxCount`=4, `oRxOverrun`=1, bytes read out are 0x01..0x04. `iRxClearErrors` clears the flag.
- **Full with simultaneous pop:** FIFO full, `iRxReady` held so the pop coincides with the stop-sample push of 0x77 → no overrun, count stays 4, 0x77 is last out.
- **Parity** (macro defined): frame 0x07 with parity bit 0 → byte pushed, `oRxParityError`=1. With the macro undefined, the same bench (parity bit omitted) keeps the flag at 0.

Source files
------------

// File: rtl/eprisc_serial_pkg.sv
// Shared types for the TTL serial receiver: FSM state encoding, data-bit count and the even-parity check.
package eprisc_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // True when data plus received parity bit hold an odd number of ones (even parity violated).
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic pbit);
    return ^{data, pbit};
  endfunction

endpackage

// File: rtl/eprisc_ttl_serial_rx_if.sv
// Consumer-side bus of the TTL serial receiver: FIFO head/handshake, occupancy and sticky error flags.
interface eprisc_ttl_serial_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       oRxData;
  logic             oRxValid;
  logic             iRxReady;
  logic [CNT_W-1:0] oRxCount;
  logic             oRxOverrun;
  logic             oRxFramingError;
  logic             oRxParityError;
  logic             iRxClearErrors;

  modport master (
    output oRxData, oRxValid, oRxCount, oRxOverrun, oRxFramingError, oRxParityError,
    input  iRxReady, iRxClearErrors
  );

  modport slave (
    input  oRxData, oRxValid, oRxCount, oRxOverrun, oRxFramingError, oRxParityError,
    output iRxReady, iRxClearErrors
  );
endinterface

// File: rtl/eprisc_rx_fifo.sv
// 8-bit first-word-fall-through FIFO; arbitrates simultaneous push/pop so a full FIFO can accept a push
// in the same cycle as a pop. FIFO_DEPTH must be a power of two.
module eprisc_rx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [7:0]                    i_push_data,
  input  logic                          i_pop,
  output logic [7:0]                    o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the head is masked to zero while empty, so stale contents never show.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/eprisc_ttl_serial_rx.sv
// TTL serial receive front end: 2-flop synchroniser, 8N1 deserialiser, FWFT byte FIFO, sticky error flags.
// Define EPRISC_TTLSERIAL_PARITY_EN to receive 8E1 frames with a live parity error flag.
module eprisc_ttl_serial_rx
  import eprisc_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                  iBoardClock,
  input  logic                  iBoardReset,
  input  logic                  iTTLSerialRX,
  eprisc_ttl_serial_rx_if.master rx_bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 r_rxs_prev;
  logic                 w_rxs;
  rx_state_e            r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [BW-1:0]        r_bit, w_bit_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 w_push, w_frame_evt, w_overrun_evt;
  logic                 w_full, w_empty;
  logic [NW-1:0]        w_count;
  logic [7:0]           w_head;
  logic                 r_overrun, r_frame_err;
`ifdef EPRISC_TTLSERIAL_PARITY_EN
  logic                 w_parity_evt, r_parity_err;
`endif

  assign w_rxs = r_sync[1];

  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      r_sync     <= 2'b11;
      r_rxs_prev <= 1'b1;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
    end else begin
      r_sync     <= {r_sync[0], iTTLSerialRX};
      r_rxs_prev <= w_rxs;
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit      <= w_bit_next;
      r_shift    <= w_shift_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_push       = 1'b0;
    w_frame_evt  = 1'b0;
`ifdef EPRISC_TTLSERIAL_PARITY_EN
    w_parity_evt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_rxs_prev && !w_rxs) begin
          w_state_next = ST_START;
          w_cnt_next   = HALF_M1;
        end
      end
      ST_START: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (w_rxs) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DATA;
          w_cnt_next   = FULL_M1;
          w_bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_cnt_next   = FULL_M1;
          w_bit_next   = r_bit + 1'b1;
          if (r_bit == LAST_BIT) begin
`ifdef EPRISC_TTLSERIAL_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef EPRISC_TTLSERIAL_PARITY_EN
      ST_PARITY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_parity_evt = parity_bad(r_shift, w_rxs);
          w_cnt_next   = FULL_M1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (w_rxs) begin
          w_push       = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_frame_evt  = 1'b1;
          w_state_next = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_rxs) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  eprisc_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (iBoardClock),
    .rst_n       (iBoardReset),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (rx_bus.iRxReady),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // A same-cycle pop frees the slot, so only a push into a full FIFO without a pop is dropped.
  assign w_overrun_evt = w_push & w_full & ~(rx_bus.iRxReady & ~w_empty);

  // A new error event wins over a coincident clear.
  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun   & ~rx_bus.iRxClearErrors) | w_overrun_evt;
      r_frame_err <= (r_frame_err & ~rx_bus.iRxClearErrors) | w_frame_evt;
    end
  end

`ifdef EPRISC_TTLSERIAL_PARITY_EN
  always_ff @(posedge iBoardClock or negedge iBoardReset) begin
    if (!iBoardReset) r_parity_err <= 1'b0;
    else              r_parity_err <= (r_parity_err & ~rx_bus.iRxClearErrors) | w_parity_evt;
  end
  assign rx_bus.oRxParityError = r_parity_err;
`else
  assign rx_bus.oRxParityError = 1'b0;
`endif

  assign rx_bus.oRxData         = w_head;
  assign rx_bus.oRxValid        = ~w_empty;
  assign rx_bus.oRxCount        = w_count;
  assign rx_bus.oRxOverrun      = r_overrun;
  assign rx_bus.oRxFramingError = r_frame_err;
endmodule

// File: tb/tb_eprisc_ttl_serial_rx.sv
// Self-checking bench for eprisc_ttl_serial_rx: table-driven frames plus hand sequences for
// latency, glitch, break, overrun and full-FIFO simultaneous pop; expected bytes held in a scoreboard queue.
module tb_eprisc_ttl_serial_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef EPRISC_TTLSERIAL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Pin fall to oRxValid: 2 sync + CPB/2 + 9 (or 10) bit times + 1.
  localparam int STOP_LAT = 2 + CPB / 2 + (PAR_EN ? 10 : 9) * CPB + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pin   = 1'b1;

  eprisc_ttl_serial_rx_if #(.FIFO_DEPTH(DEPTH)) rx_bus ();

  eprisc_ttl_serial_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .iBoardClock  (clk),
    .iBoardReset  (rst_n),
    .iTTLSerialRX (pin),
    .rx_bus       (rx_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       bad_par;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr  = 1'b0;
  int         lat;
  vec_t       vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard model: a byte is kept only if the FIFO has room, otherwise overrun is expected.
  task automatic expect_byte(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr = 1'b1;
  endtask

  // Called at a negedge; drives one frame with pin changes on negedges.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                            input logic release_line);
    pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pin = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      pin = (^d) ^ bad_par;
      repeat (CPB) @(negedge clk);
    end
    pin = stop_bit;
    repeat (CPB) @(negedge clk);
    if (release_line) pin = 1'b1;
  endtask

  task automatic pop_check(input string name);
    check({name, " valid"}, rx_bus.oRxValid, 1'b1);
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      check({name, " data"}, rx_bus.oRxData, exp_q[0]);
      rx_bus.iRxReady = 1'b1;
      @(negedge clk);
      rx_bus.iRxReady = 1'b0;
      void'(exp_q.pop_front());
      check({name, " count after pop"}, rx_bus.oRxCount, exp_q.size());
    end
  endtask

  task automatic clear_errors();
    rx_bus.iRxClearErrors = 1'b1;
    @(negedge clk);
    rx_bus.iRxClearErrors = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    rx_bus.iRxReady       = 1'b0;
    rx_bus.iRxClearErrors = 1'b0;
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset data", rx_bus.oRxData, 8'h00);
    check("reset valid", rx_bus.oRxValid, 1'b0);
    check("reset count", rx_bus.oRxCount, 0);
    check("reset overrun", rx_bus.oRxOverrun, 1'b0);
    check("reset ferr", rx_bus.oRxFramingError, 1'b0);
    check("reset perr", rx_bus.oRxParityError, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with pin-accurate latency
    expect_byte(8'h55);
    fork
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      begin
        lat = 0;
        while (!rx_bus.oRxValid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("single latency", lat, STOP_LAT);
    check("single count", rx_bus.oRxCount, 1);
    pop_check("single pop");
    check("single valid drop", rx_bus.oRxValid, 1'b0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      clear_errors();
      if (vecs[v].exp_valid) expect_byte(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].bad_par, 1'b1);
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d valid", v), rx_bus.oRxValid, vecs[v].exp_valid);
      check($sformatf("vec%0d ferr", v), rx_bus.oRxFramingError, vecs[v].exp_ferr);
      check($sformatf("vec%0d perr", v), rx_bus.oRxParityError, vecs[v].bad_par & PAR_EN);
      check($sformatf("vec%0d count", v), rx_bus.oRxCount, exp_q.size());
      if (vecs[v].exp_valid) pop_check($sformatf("vec%0d pop", v));
    end
    clear_errors();

    // Glitch: short low pulse, then a clean frame proves the receiver is back in IDLE
    pin = 1'b0;
    repeat (4) @(negedge clk);
    pin = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch valid", rx_bus.oRxValid, 1'b0);
    check("glitch ferr", rx_bus.oRxFramingError, 1'b0);
    check("glitch overrun", rx_bus.oRxOverrun, 1'b0);
    check("glitch perr", rx_bus.oRxParityError, 1'b0);
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    pop_check("after glitch");

    // Framing error followed by a 40-bit-time break
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    check("break ferr", rx_bus.oRxFramingError, 1'b1);
    check("break count", rx_bus.oRxCount, 0);
    clear_errors();
    repeat (20 * CPB) @(negedge clk);
    check("break single ferr", rx_bus.oRxFramingError, 1'b0);
    pin = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check("post-break ferr", rx_bus.oRxFramingError, 1'b0);
    pop_check("post-break");

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      expect_byte(8'(i));
      send_frame(8'(i), 1'b1, 1'b0, 1'b1);
    end
    repeat (8) @(negedge clk);
    check("overrun count", rx_bus.oRxCount, exp_q.size());
    check("overrun flag", rx_bus.oRxOverrun, exp_ovr);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("overrun drain%0d", i));
    clear_errors();
    check("overrun cleared", rx_bus.oRxOverrun, 1'b0);

    // Full FIFO with a pop coinciding with the stop-sample push of 0x77
    for (int i = 0; i < DEPTH; i++) begin
      expect_byte(8'(8'h10 + i));
      send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b1);
    end
    repeat (8) @(negedge clk);
    check("simul prefill count", rx_bus.oRxCount, DEPTH);
    fork
      send_frame(8'h77, 1'b1, 1'b0, 1'b1);
      begin
        repeat (STOP_LAT - 1) @(negedge clk);
        check("simul head", rx_bus.oRxData, exp_q[0]);
        rx_bus.iRxReady = 1'b1;
        @(negedge clk);
        rx_bus.iRxReady = 1'b0;
        void'(exp_q.pop_front());
        expect_byte(8'h77);
      end
    join
    repeat (8) @(negedge clk);
    check("simul overrun", rx_bus.oRxOverrun, exp_ovr);
    check("simul count", rx_bus.oRxCount, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("simul drain%0d", i));
    check("final valid", rx_bus.oRxValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
